// File: rtl/data_sram_responder.sv
// SRAM-like data port responder: in-order request FIFO in front of a byte-writable
// 32-bit memory, each completion spaced at least LATENCY cycles after its entry becomes head.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       LOAD_WAIT = 4'(LATENCY - 1);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] idx;
        logic [3:0]            mask;
        logic [31:0]           wdata;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    entry_t           fifo [FIFO_DEPTH];
    logic [31:0]      mem  [2**ADDR_WIDTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic [3:0]       wait_cnt, wait_cnt_nxt;
    state_t           state, state_nxt;
    logic [3:0]       byte_mask;
    logic             push, pop;
    entry_t           head;

    // High address bits alias onto the same word by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^data_addr[31:ADDR_WIDTH+2];

    always_comb begin
        byte_mask = 4'b1111;
        case (data_size)
            2'd0:    byte_mask = 4'b0001 << data_addr[1:0];
            2'd1:    byte_mask = data_addr[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    end

    assign head         = fifo[rd_ptr];
    assign data_addr_ok = data_req & (count != FULL_CNT) & ~rst;
    assign push         = data_addr_ok;
    assign data_data_ok = (state == RESP) & ~rst;
    assign pop          = data_data_ok;
    assign busy         = (count != '0) & ~rst;
    assign data_rdata   = (data_data_ok && !head.wr) ? mem[head.idx] : '0;

    // A new head (after a push into empty, or after a pop) restarts the wait counter.
    always_comb begin
        count_nxt    = count;
        wait_cnt_nxt = wait_cnt;
        state_nxt    = state;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        if (count_nxt != '0 && (count == '0 || pop))
            wait_cnt_nxt = LOAD_WAIT;
        else if (wait_cnt != '0)
            wait_cnt_nxt = wait_cnt - 4'd1;
        if (count_nxt == '0)
            state_nxt = IDLE;
        else if (wait_cnt_nxt == '0)
            state_nxt = RESP;
        else
            state_nxt = WAIT;
    end

    // NOTE: every clocked register uses non-blocking assignment so all state
    // updates see the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: FIFO payload and memory arrays carry no reset; validity comes from
    // count, and memory contents must survive rst.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{wr: data_wr, idx: data_addr[ADDR_WIDTH+1:2],
                              mask: byte_mask, wdata: data_wdata};
    end

    always_ff @(posedge clk) begin
        if (pop && head.wr) begin
            for (int b = 0; b < 4; b++)
                if (head.mask[b]) mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for single-cycle throughput.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok, busy;

    logic        req1, wr1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        aok1, dok1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .busy(busy)
    );

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .data_req(req1), .data_wr(wr1),
        .data_size(size1), .data_addr(addr1), .data_wdata(wdata1),
        .data_rdata(rdata1), .data_addr_ok(aok1),
        .data_data_ok(dok1), .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on dut, then wait (bounded) for its data_ok.
    // lat is cycles from acceptance to data_ok, -1 on timeout.
    task automatic xact(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic acc, output int lat,
                        output logic [31:0] rd);
        logic done;
        done = 1'b0;
        lat  = -1;
        rd   = '0;
        data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
        #2 acc = data_addr_ok;
        step();
        data_req = 1'b0;
        for (int i = 1; i <= 20 && !done; i++) begin
            #2;
            if (data_data_ok) begin
                done = 1'b1;
                lat  = i;
                rd   = data_rdata;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h10; data_wdata = '0;
        req1 = 1'b1; wr1 = 1'b0; size1 = 2'd2; addr1 = 32'h40; wdata1 = '0;
        step(); step();
        #2;
        checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL rst_addr_ok got %b want 0", data_addr_ok); end
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_ok got %b want 0", data_data_ok); end
        checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", data_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (aok1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL rst_l1 got aok=%b busy=%b want 0 0", aok1, busy1); end
        step();
        rst = 1'b0; data_req = 1'b0; req1 = 1'b0;
        #2;
        checks++; if (busy !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL post_rst got busy=%b dok=%b want 0 0", busy, data_data_ok); end
        step();
    endtask

    task automatic test_write_read();
        logic acc; int lat; logic [31:0] rd;
        xact(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, acc, lat, rd);
        checks++; if (acc !== 1'b1 || lat != 2) begin errors++; $display("FAIL wr_latency got acc=%b lat=%0d want 1 2", acc, lat); end
        xact(1'b0, 2'd2, 32'h10, 32'h0, acc, lat, rd);
        checks++; if (acc !== 1'b1 || lat != 2) begin errors++; $display("FAIL rd_latency got acc=%b lat=%0d want 1 2", acc, lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        logic acc; int lat; logic [31:0] rd;
        xact(1'b1, 2'd0, 32'h12, 32'h00AA0000, acc, lat, rd);
        xact(1'b0, 2'd2, 32'h10, 32'h0, acc, lat, rd);
        checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL byte_write got %h want deaabeef", rd); end
        xact(1'b1, 2'd1, 32'h10, 32'h00001234, acc, lat, rd);
        xact(1'b0, 2'd2, 32'h10, 32'h0, acc, lat, rd);
        checks++; if (rd !== 32'hDEAA1234) begin errors++; $display("FAIL half_write got %h want deaa1234", rd); end
        xact(1'b1, 2'd0, 32'h13, 32'h77000000, acc, lat, rd);
        xact(1'b0, 2'd2, 32'h0000_1010, 32'h0, acc, lat, rd);
        checks++; if (rd !== 32'h77AA1234) begin errors++; $display("FAIL alias_read got %h want 77aa1234", rd); end
        xact(1'b1, 2'd3, 32'h24, 32'h0BADCAFE, acc, lat, rd);
        xact(1'b0, 2'd2, 32'h24, 32'h0, acc, lat, rd);
        checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL size3_word got %h want 0badcafe", rd); end
    endtask

    task automatic test_fill();
        logic [7:0] aok_seen, dok_seen;
        int accepted, completed;
        accepted = 0; completed = 0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h10;
        for (int i = 0; i < 8; i++) begin
            #2;
            aok_seen[i] = data_addr_ok;
            dok_seen[i] = data_data_ok;
            if (data_addr_ok) accepted++;
            if (data_data_ok) completed++;
            step();
        end
        data_req = 1'b0;
        checks++; if (aok_seen !== 8'b1010_1011) begin errors++; $display("FAIL fill_addr_ok got %b want 10101011", aok_seen); end
        checks++; if (dok_seen !== 8'b0101_0100) begin errors++; $display("FAIL fill_data_ok got %b want 01010100", dok_seen); end
        for (int i = 0; i < 20 && busy; i++) begin
            #2;
            if (data_data_ok) completed++;
            step();
        end
        #2;
        checks++; if (busy !== 1'b0 || completed != 5 || accepted != 5) begin
            errors++; $display("FAIL fill_drain got busy=%b acc=%0d done=%0d want 0 5 5", busy, accepted, completed);
        end
        step();
    endtask

    task automatic test_back_to_back();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h20; data_wdata = 32'h12345678;
        #2;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_wr_accept got %b want 1", data_addr_ok); end
        step();
        data_wr = 1'b0; data_wdata = 32'h0;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_rd_accept got aok=%b dok=%b want 1 0", data_addr_ok, data_data_ok); end
        step();
        data_req = 1'b0;
        #2;
        checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h0) begin errors++; $display("FAIL b2b_wr_done got dok=%b rdata=%h want 1 0", data_data_ok, data_rdata); end
        step();
        #2;
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", data_data_ok); end
        step();
        #2;
        checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_rd_done got dok=%b rdata=%h want 1 12345678", data_data_ok, data_rdata); end
        step();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        step();
    endtask

    task automatic test_reset_mid();
        logic acc; int lat; logic [31:0] rd; int stray;
        stray = 0;
        xact(1'b1, 2'd2, 32'h30, 32'h11111111, acc, lat, rd);
        xact(1'b1, 2'd2, 32'h34, 32'h22222222, acc, lat, rd);
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h30; data_wdata = 32'hAAAAAAAA;
        step();
        data_addr = 32'h34; data_wdata = 32'hBBBBBBBB;
        #2;
        checks++; if (data_addr_ok !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_two_pending got aok=%b busy=%b want 1 1", data_addr_ok, busy); end
        step();
        data_req = 1'b0; rst = 1'b1;
        #2;
        checks++; if (data_data_ok !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst got dok=%b busy=%b want 0 0", data_data_ok, busy); end
        step();
        rst = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy got %b want 0", busy); end
        for (int i = 0; i < 5; i++) begin
            if (data_data_ok) stray++;
            step();
            #2;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_stray_ok got %0d want 0", stray); end
        step();
        xact(1'b0, 2'd2, 32'h30, 32'h0, acc, lat, rd);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL mid_mem30 got %h want 11111111", rd); end
        xact(1'b0, 2'd2, 32'h34, 32'h0, acc, lat, rd);
        checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL mid_mem34 got %h want 22222222", rd); end
    endtask

    task automatic test_latency1();
        req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2; addr1 = 32'h40; wdata1 = 32'hCAFEF00D;
        #2;
        checks++; if (aok1 !== 1'b1 || dok1 !== 1'b0) begin errors++; $display("FAIL l1_c0 got aok=%b dok=%b want 1 0", aok1, dok1); end
        step();
        wr1 = 1'b0; wdata1 = 32'h0;
        #2;
        checks++; if (aok1 !== 1'b1 || dok1 !== 1'b1) begin errors++; $display("FAIL l1_c1 got aok=%b dok=%b want 1 1", aok1, dok1); end
        step();
        #2;
        checks++; if (dok1 !== 1'b1 || rdata1 !== 32'hCAFEF00D) begin errors++; $display("FAIL l1_c2 got dok=%b rdata=%h want 1 cafef00d", dok1, rdata1); end
        step();
        req1 = 1'b0;
        #2;
        checks++; if (dok1 !== 1'b1 || rdata1 !== 32'hCAFEF00D) begin errors++; $display("FAIL l1_c3 got dok=%b rdata=%h want 1 cafef00d", dok1, rdata1); end
        step();
        #2;
        checks++; if (dok1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL l1_c4 got dok=%b busy=%b want 0 0", dok1, busy1); end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
